trig_wfm_capture: RTL

- Consumer side of the internal trigger path: accepts the level trigger from the ADC threshold trigger block together with the same 14-bit ADC sample stream.
- On each accepted trigger, freezes a window of pre-trigger and post-trigger samples in a circular buffer.
- Streams the window out over a valid/ready interface, along with a latched timestamp and a lost-trigger count.
- Sits between the ADC data path and the comm/readout logic.

---
 rtl/trig_wfm_capture.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/trig_wfm_capture.sv
// Trigger-driven waveform capture.
// Keeps a circular history of ADC samples. On an accepted trigger edge it freezes a window of
// PRE_SAMPLES pre-trigger and POST_SAMPLES post-trigger samples (trigger sample included).
// It then streams that window out in time order over a valid/ready interface.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   tdat, itrig     : ADC sample stream and level trigger from the threshold block
//   o_data/o_valid/i_ready/o_sop/o_eop : readout stream (one window = DEPTH beats)
//   o_tstamp        : free-running count latched at the accepted trigger
//   o_lost          : saturating count of trigger edges that were ignored
//   o_busy          : low only while armed and waiting for a trigger
module trig_wfm_capture #(
    parameter int unsigned PRE_SAMPLES  = 16,
    parameter int unsigned POST_SAMPLES = 48,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned AW           = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] tdat,
    input  logic        itrig,
    output logic [13:0] o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_sop,
    output logic        o_eop,
    output logic [31:0] o_tstamp,
    output logic [15:0] o_lost,
    output logic        o_busy
);

    localparam int unsigned DW = 14;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_FILL,
        S_ARMED,
        S_POST,
        S_READ
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [DW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  fill_cnt;
    logic [CW-1:0]  post_cnt;
    logic [CW-1:0]  beat_cnt;
    logic [31:0]    ts_cnt;
    logic           itrig_d;
    logic           trg_edge;
    logic           wr_en;
    logic           trig_take;
    logic           lost_inc;
    logic           load_beat;
    logic           read_done;

    assign trg_edge = itrig & ~itrig_d;

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        trig_take = 1'b0;
        lost_inc  = 1'b0;
        load_beat = 1'b0;
        read_done = 1'b0;
        case (state)
            S_FILL: begin
                wr_en    = 1'b1;
                lost_inc = trg_edge;
                // This cycle stores the last required pre-trigger sample
                if (fill_cnt == CW'(PRE_SAMPLES - 1)) begin
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                wr_en = 1'b1;
                if (trg_edge) begin
                    trig_take = 1'b1;
                    state_nxt = S_POST;
                end
            end
            S_POST: begin
                wr_en    = 1'b1;
                lost_inc = trg_edge;
                if (post_cnt == CW'(POST_SAMPLES - 1)) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                lost_inc  = trg_edge;
                // Refill the output register whenever it is empty or being consumed
                load_beat = (~o_valid | i_ready) & (beat_cnt != CW'(DEPTH));
                if (o_valid & i_ready & o_eop) begin
                    read_done = 1'b1;
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // Sample buffer; no reset needed, history is re-acquired after every reset/readout
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= tdat;
        end
    end

    // State register, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FILL;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_cnt <= '0;
            post_cnt <= '0;
            beat_cnt <= '0;
            ts_cnt   <= '0;
            itrig_d  <= 1'b0;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_sop    <= 1'b0;
            o_eop    <= 1'b0;
            o_tstamp <= '0;
            o_lost   <= '0;
            o_busy   <= 1'b1;
        end else begin
            state   <= state_nxt;
            itrig_d <= itrig;
            ts_cnt  <= ts_cnt + 32'd1;
            o_busy  <= (state_nxt != S_ARMED);

            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (state == S_FILL) begin
                fill_cnt <= fill_cnt + CW'(1);
            end
            if (read_done) begin
                fill_cnt <= '0;
            end
            if (lost_inc && (o_lost != 16'hFFFF)) begin
                o_lost <= o_lost + 16'd1;
            end

            // Trigger sample lands at wr_ptr; window starts PRE_SAMPLES earlier
            if (trig_take) begin
                o_tstamp <= ts_cnt;
                rd_ptr   <= wr_ptr - AW'(PRE_SAMPLES);
                post_cnt <= CW'(1);
                beat_cnt <= '0;
            end
            if (state == S_POST) begin
                post_cnt <= post_cnt + CW'(1);
            end

            if (load_beat) begin
                o_data   <= mem[rd_ptr];
                o_valid  <= 1'b1;
                o_sop    <= (beat_cnt == CW'(0));
                o_eop    <= (beat_cnt == CW'(DEPTH - 1));
                rd_ptr   <= rd_ptr + AW'(1);
                beat_cnt <= beat_cnt + CW'(1);
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
                o_sop   <= 1'b0;
                o_eop   <= 1'b0;
            end
        end
    end

endmodule
